irq_arbiter: RTL and testbench

//  External interrupt arbiter feeding the clint's int_flag input. Synchronizes NUM_SRC async sources,

---
 rtl/irq_arbiter_pkg.sv | 20 ++
 rtl/irq_gateway.sv | 51 +++++
 rtl/irq_arbiter.sv | 124 ++++++++++++
 tb/tb_irq_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_arbiter_pkg.sv
// Shared constants and types for the external interrupt arbiter.
// Register offsets, gateway state codes and clint-side interrupt IDs.
package irq_arbiter_pkg;

  localparam logic [4:0] IRQ_ARB_PENDING  = 5'h00;
  localparam logic [4:0] IRQ_ARB_ENABLE   = 5'h04;
  localparam logic [4:0] IRQ_ARB_EDGE_SEL = 5'h08;
  localparam logic [4:0] IRQ_ARB_CLAIM    = 5'h0C;
  localparam logic [4:0] IRQ_ARB_COMPLETE = 5'h10;

  localparam int         INT_BUS  = 8;
  localparam logic [7:0] INT_NONE = 8'h0;

  typedef enum logic [1:0] {
    GW_IDLE   = 2'd0,
    GW_PEND   = 2'd1,
    GW_ACTIVE = 2'd2
  } gw_state_e;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: 2-flop sync, edge-detect flop and
// IDLE/PEND/ACTIVE state machine.
module irq_gateway
  import irq_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic edge_sel,
  input  logic claim,
  input  logic complete,
  output logic pend
);

  logic s1, s2, s3;
  logic trig;
  gw_state_e state, state_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign trig = edge_sel ? (s2 & ~s3) : s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GW_IDLE;
    else     state <= state_nx;
  end

  // Triggers seen outside IDLE are dropped on purpose
  always_comb begin
    state_nx = state;
    unique case (state)
      GW_IDLE:   if (trig)     state_nx = GW_PEND;
      GW_PEND:   if (claim)    state_nx = GW_ACTIVE;
      GW_ACTIVE: if (complete) state_nx = GW_IDLE;
      default:                 state_nx = GW_IDLE;
    endcase
  end

  assign pend = (state == GW_PEND);

endmodule

// File: rtl/irq_arbiter.sv
// PLIC-lite external interrupt arbiter feeding clint int_flag.
// Define IRQ_ARB_RR_EN for round-robin instead of fixed priority.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  input  logic               we_i,
  input  logic               re_i,
  output logic [31:0]        data_o,
  output logic [INT_BUS-1:0] int_flag_o
);

  logic [4:0]         off;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] edge_sel;
  logic [NUM_SRC-1:0] cand;
  logic               claim_hit;
  logic               comp_hit;
  logic               win_found;
  logic [4:0]         win_idx;
  logic               unused_bits;

  assign off         = addr_i[4:0];
  assign unused_bits = ^{addr_i[31:5], data_i};

  assign claim_hit = re_i && (off == IRQ_ARB_CLAIM)
                  && (int_flag_o != INT_NONE);
  assign comp_hit  = we_i && (off == IRQ_ARB_COMPLETE);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_gw
    irq_gateway u_gw (
      .clk      (clk),
      .rst      (rst),
      .irq      (irq_i[i]),
      .edge_sel (edge_sel[i]),
      .claim    (claim_hit
                 && (int_flag_o == 8'(i + 1))),
      .complete (comp_hit
                 && (data_i[4:0] == 5'(i + 1))),
      .pend     (pend[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable   <= '0;
      edge_sel <= '0;
    end else if (we_i) begin
      if (off == IRQ_ARB_ENABLE)
        enable <= data_i[NUM_SRC-1:0];
      if (off == IRQ_ARB_EDGE_SEL)
        edge_sel <= data_i[NUM_SRC-1:0];
    end
  end

  assign cand = pend & enable;

`ifdef IRQ_ARB_RR_EN
  logic [4:0] rr_ptr;
  int         k;

  // Pointer holds the search start: (claimed index + 1) mod NUM_SRC
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (claim_hit)
      rr_ptr <= (int_flag_o[4:0] >= 5'(NUM_SRC))
              ? 5'd0 : int_flag_o[4:0];
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    k         = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      k = (int'(rr_ptr) + i) % NUM_SRC;
      if (!win_found && cand[k]) begin
        win_found = 1'b1;
        win_idx   = 5'(k);
      end
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_found = 1'b1;
        win_idx   = 5'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      int_flag_o <= INT_NONE;
    else if (win_found)
      int_flag_o <= 8'(win_idx) + 8'd1;
    else
      int_flag_o <= INT_NONE;
  end

  always_comb begin
    data_o = '0;
    unique case (1'b1)
      (off == IRQ_ARB_PENDING):  data_o = 32'(pend);
      (off == IRQ_ARB_ENABLE):   data_o = 32'(enable);
      (off == IRQ_ARB_EDGE_SEL): data_o = 32'(edge_sel);
      (off == IRQ_ARB_CLAIM):
        data_o = {27'b0, int_flag_o[4:0]};
      default:                   data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter (fixed priority).
// Covers claim/complete flow, level re-trigger, masking and reset.
module tb_irq_arbiter;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_i;
  logic [31:0]   addr_i;
  logic [31:0]   data_i;
  logic          we_i;
  logic          re_i;
  logic [31:0]   data_o;
  logic [7:0]    int_flag_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] rv;

  irq_arbiter #(.NUM_SRC(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_i      (irq_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .we_i       (we_i),
    .re_i       (re_i),
    .data_o     (data_o),
    .int_flag_o (int_flag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    tick();
    we_i   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d);
    addr_i = a;
    #1;
    d = data_o;
  endtask

  task automatic claim(output logic [31:0] d);
    addr_i = 32'h0C;
    re_i   = 1'b1;
    #1;
    d = data_o;
    tick();
    re_i = 1'b0;
  endtask

  // High for exactly one sampling edge
  task automatic pulse(input logic [N-1:0] m);
    irq_i = irq_i | m;
    tick();
    irq_i = irq_i & ~m;
  endtask

  initial begin
    rst    = 1'b1;
    irq_i  = '0;
    addr_i = '0;
    data_i = '0;
    we_i   = 1'b0;
    re_i   = 1'b0;
    ticks(2);

    check("rst_flag", 32'(int_flag_o), 32'h0);
    rd(32'h00, rv); check("rst_pend", rv, 32'h0);
    rd(32'h04, rv); check("rst_en", rv, 32'h0);
    rd(32'h08, rv); check("rst_edge", rv, 32'h0);
    rst = 1'b0;
    tick();
    rd(32'h14, rv); check("bad_off", rv, 32'h0);

    // 1: single edge pulse, claim, complete
    wr(32'h04, 32'hFF);
    wr(32'h08, 32'hFF);
    rd(32'h08, rv); check("t1_edge_rb", rv, 32'hFF);
    pulse(8'h04);
    ticks(2);
    check("t1_flag_e3", 32'(int_flag_o), 32'h0);
    rd(32'h00, rv); check("t1_pend_e3", rv, 32'h04);
    tick();
    check("t1_flag_e4", 32'(int_flag_o), 32'h3);
    claim(rv); check("t1_claim", rv, 32'h3);
    tick();
    check("t1_flag_clr", 32'(int_flag_o), 32'h0);
    rd(32'h00, rv); check("t1_pend_clr", rv, 32'h0);
    wr(32'h10, 32'h3);

    // 2: two sources, lowest index first
    pulse(8'h22);
    ticks(3);
    check("t2_flag", 32'(int_flag_o), 32'h2);
    claim(rv); check("t2_claim_a", rv, 32'h2);
    tick();
    check("t2_flag_b", 32'(int_flag_o), 32'h6);
    claim(rv); check("t2_claim_b", rv, 32'h6);
    tick();
    check("t2_flag_0", 32'(int_flag_o), 32'h0);
    wr(32'h10, 32'h2);
    wr(32'h10, 32'h6);

    // 3: level source re-pends after complete
    wr(32'h08, 32'hFE);
    irq_i[0] = 1'b1;
    ticks(4);
    check("t3_flag", 32'(int_flag_o), 32'h1);
    claim(rv); check("t3_claim", rv, 32'h1);
    tick();
    check("t3_flag_0", 32'(int_flag_o), 32'h0);
    wr(32'h10, 32'h1);
    rd(32'h00, rv); check("t3_idle", rv, 32'h0);
    tick();
    rd(32'h00, rv); check("t3_repend", rv, 32'h1);
    tick();
    check("t3_reflag", 32'(int_flag_o), 32'h1);
    irq_i[0] = 1'b0;
    ticks(3);
    claim(rv); check("t3_claim2", rv, 32'h1);
    wr(32'h10, 32'h1);
    wr(32'h08, 32'hFF);
    tick();
    rd(32'h00, rv); check("t3_done", rv, 32'h0);

    // 4: pending latches while masked
    wr(32'h04, 32'h00);
    pulse(8'h08);
    ticks(3);
    rd(32'h00, rv); check("t4_pend", rv, 32'h08);
    check("t4_flag_m", 32'(int_flag_o), 32'h0);
    wr(32'h04, 32'h08);
    tick();
    check("t4_flag", 32'(int_flag_o), 32'h4);
    rd(32'h04, rv); check("t4_en_rb", rv, 32'h08);
    claim(rv); check("t4_claim", rv, 32'h4);
    wr(32'h10, 32'h4);
    wr(32'h04, 32'hFF);

    // 5: bogus complete, dropped re-trigger
    pulse(8'h40);
    ticks(3);
    check("t5_flag", 32'(int_flag_o), 32'h7);
    wr(32'h10, 32'h7);
    tick();
    check("t5_flag_kept", 32'(int_flag_o), 32'h7);
    rd(32'h00, rv); check("t5_pend_kept", rv, 32'h40);
    claim(rv); check("t5_claim", rv, 32'h7);
    wr(32'h10, 32'h7);
    wr(32'h10, 32'h0);
    wr(32'h10, 32'h1F);
    tick();
    rd(32'h00, rv); check("t5_idle", rv, 32'h0);
    pulse(8'h04);
    ticks(3);
    claim(rv); check("t5_claim3", rv, 32'h3);
    pulse(8'h04);
    ticks(3);
    rd(32'h00, rv); check("t5_drop", rv, 32'h0);
    check("t5_drop_f", 32'(int_flag_o), 32'h0);
    wr(32'h10, 32'h3);
    ticks(3);
    rd(32'h00, rv); check("t5_after", rv, 32'h0);

    // 6: async reset mid-operation
    pulse(8'h02);
    ticks(3);
    claim(rv); check("t6_claim", rv, 32'h2);
    pulse(8'h10);
    ticks(3);
    check("t6_flag", 32'(int_flag_o), 32'h5);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_flag", 32'(int_flag_o), 32'h0);
    rd(32'h00, rv); check("t6_rst_pend", rv, 32'h0);
    rd(32'h04, rv); check("t6_rst_en", rv, 32'h0);
    tick();
    rst = 1'b0;
    ticks(2);
    check("t6_post", 32'(int_flag_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
